pdm_output_stage: RTL
=====================

Name: pdm_output_stage

Overview:
- Audio output stage directly downstream of the tone generator mixer.
- Takes each 16-bit signed mixed sample and its one-cycle valid strobe (issued once per 1024-clock frame).
- Optionally ramps linearly from the previous sample to the new one across one frame.
- Drives a first-order delta-sigma modulator that produces a 1-bit PDM stream for an external RC filter.
- Also watches for a missing upstream sample and fades the output to silence.

Parameters:
- FRAME_LOG2, 10, log2 of the clocks per sample frame; ramp length is 2^FRAME_LOG2 clocks.
- UNDERRUN_FRAMES, 2, number of frames without a valid strobe before underrun is declared.

Ports:
- clk_in  input  1  system clock
- reset_n_in  input  1  reset, asynchronous assert, active-low
- sample_in  input  16  signed two's-complement mixed sample
- sample_valid_in  input  1  one-cycle strobe; sample_in is valid in that cycle
- interp_en_in  input  1  1 = linear ramp to each new sample; 0 = step immediately
- level_out  output  16  current signed level fed to the modulator
- pdm_out  output  1  registered PDM bit
- underrun_out  output  1  high while in underrun

Behaviour:
- Reset (reset_n_in=0, asynchronous) clears all of the following; their values are 0 while reset is held:
  - acc (26-bit signed, value×2^FRAME_LOG2)
  - step (17-bit signed)
  - ramp_cnt (FRAME_LOG2 bits)
  - state
  - err (16-bit)
  - pdm_out
  - underrun_out
  - watchdog counter
- level_out = acc[25:10] (top 16 bits, generalised for FRAME_LOG2), combinational from acc.
- States:
  - HOLD: acc constant.
  - RAMP: acc <= acc + sign-extend(step) every clock; ramp_cnt increments.
- Transitions:
  - RAMP -> HOLD when ramp_cnt reaches 2^FRAME_LOG2-1 on an add cycle; that cycle performs the last add, and step is cleared.
  - On sample_valid_in with interp_en_in=1 (from either state):
    - step <= sext(sample_in) - level_out (17-bit, no saturation needed).
    - acc <= {level_out, zero fraction}, which snaps to the current integer level.
    - ramp_cnt <= 0; state <= RAMP.
    - The first add happens on the next clock.
    - After exactly 2^FRAME_LOG2 adds, acc equals sample_in×2^FRAME_LOG2 exactly.
  - On sample_valid_in with interp_en_in=0:
    - acc <= {sample_in, zero fraction}; step <= 0; state <= HOLD.
    - level_out equals sample_in on the next clock.
- A valid strobe arriving mid-ramp abandons the ramp. The new ramp starts from the integer level at that moment; the fractional part is discarded.
- Watchdog:
  - Counts clocks since the last sample_valid_in; saturates.
  - At UNDERRUN_FRAMES×2^FRAME_LOG2 clocks without a strobe: underrun_out <= 1, and a ramp to 0 is started. This behaves as if a valid strobe carried sample 0 with interp_en_in=1.
  - The internal ramp is started once per underrun, not repeatedly.
  - The next sample_valid_in clears underrun_out in the same edge and is processed normally.
- Modulator (runs every clock, independent of state):
  - u = level_out XOR 0x8000 (offset binary, 0x0000..0xFFFF).
  - sum = {1'b0, err} + {1'b0, u} (17-bit).
  - pdm_out <= sum[16]; err <= sum[15:0].
  - Long-run density of ones = u/65536.
- Sample handling during reset: sample_valid_in is ignored while reset_n_in=0. The first strobe after release behaves normally from level 0.
- No backpressure: the upstream stage cannot be stalled; every strobe is accepted.

Test Plan:
- Release reset, no strobes, level_out=0 -> pdm_out sequence 0,1,0,1,… (err 0x8000, 0x0000 alternating); underrun_out stays 0 for the first 2047 clocks after reset.
- interp_en_in=0, strobe sample_in=0x7FFF -> next clock level_out=0x7FFF; pdm_out=1 on all but 1 of every 65536 clocks (u=0xFFFF).
- interp_en_in=1 from level 0, strobe 0x0400 -> level_out=0x0001 after 1 add, 0x0200 after 512 adds, 0x0400 after 1024 adds, then holds.
- interp_en_in=1, strobe 0x1000, then strobe 0xF000 (-4096) after 256 clocks -> second ramp starts from 0x0400; level_out=0xF000 exactly 1024 adds later.
- Ramp to 0x2000 completed, then no strobes for 2048 clocks -> underrun_out=1, level_out ramps to 0 over 1024 clocks; a following strobe of 0x0100 clears underrun_out on that edge.
- Assert reset_n_in low asynchronously mid-ramp -> level_out, pdm_out and underrun_out go 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pdm_output_stage.sv
// Audio output stage: optional linear ramp between frame samples, underrun fade-to-silence,
// and a first-order delta-sigma modulator producing a 1-bit PDM stream.
module pdm_output_stage #(
   parameter int FRAME_LOG2      = 10,
   parameter int UNDERRUN_FRAMES = 2
) (
   input  logic        clk_in,
   input  logic        reset_n_in,
   input  logic [15:0] sample_in,
   input  logic        sample_valid_in,
   input  logic        interp_en_in,
   output logic [15:0] level_out,
   output logic        pdm_out,
   output logic        underrun_out,
   output logic        dbg_state_out
);

   localparam int ACC_W    = 16 + FRAME_LOG2;
   localparam int WD_LIMIT = UNDERRUN_FRAMES << FRAME_LOG2;
   localparam int WD_W     = $clog2(WD_LIMIT + 1);

   localparam logic [FRAME_LOG2-1:0] CNT_LAST = '1;
   localparam logic [WD_W-1:0]       WD_MAX   = WD_W'(WD_LIMIT);
   localparam logic [WD_W-1:0]       WD_FIRE  = WD_W'(WD_LIMIT - 1);

   typedef enum logic [0:0] {
      HOLD = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [16:0]             step_q, step_d;
   logic [FRAME_LOG2-1:0]   ramp_cnt_q, ramp_cnt_d;
   logic [15:0]             err_q, err_d;
   logic                    pdm_q, pdm_d;
   logic                    underrun_q, underrun_d;
   logic [WD_W-1:0]         wd_q, wd_d;

   logic [15:0] level;
   logic [15:0] target;
   logic [15:0] u;
   logic [16:0] sum;
   logic        wd_fire;
   logic        start_ramp;

   assign level         = acc_q[ACC_W-1 -: 16];
   assign level_out     = level;
   assign pdm_out       = pdm_q;
   assign underrun_out  = underrun_q;
   assign dbg_state_out = state_q;

   // The watchdog saturates one past the fire value, so the fade-out ramp starts once per underrun.
   assign wd_fire    = !sample_valid_in && (wd_q == WD_FIRE);
   assign start_ramp = (sample_valid_in && interp_en_in) || wd_fire;
   assign target     = sample_valid_in ? sample_in : 16'h0000;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      step_d     = step_q;
      ramp_cnt_d = ramp_cnt_q;

      if (start_ramp) begin
         // Snap to the integer level; any fractional residue of an abandoned ramp is dropped.
         step_d     = {target[15], target} - {level[15], level};
         acc_d      = {level, {FRAME_LOG2{1'b0}}};
         ramp_cnt_d = '0;
         state_d    = RAMP;
      end else if (sample_valid_in) begin
         step_d     = '0;
         acc_d      = {sample_in, {FRAME_LOG2{1'b0}}};
         ramp_cnt_d = '0;
         state_d    = HOLD;
      end else if (state_q == RAMP) begin
         acc_d      = acc_q + {{(ACC_W-17){step_q[16]}}, step_q};
         ramp_cnt_d = ramp_cnt_q + 1'b1;
         if (ramp_cnt_q == CNT_LAST) begin
            state_d = HOLD;
            step_d  = '0;
         end
      end
   end

   always_comb begin
      wd_d       = wd_q;
      underrun_d = underrun_q;
      if (sample_valid_in) begin
         wd_d       = '0;
         underrun_d = 1'b0;
      end else begin
         if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
         end
         if (wd_fire) begin
            underrun_d = 1'b1;
         end
      end
   end

   // Offset-binary level into a first-order error-feedback accumulator; carry-out is the PDM bit.
   always_comb begin
      u     = level ^ 16'h8000;
      sum   = {1'b0, err_q} + {1'b0, u};
      pdm_d = sum[16];
      err_d = sum[15:0];
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q    <= HOLD;
         acc_q      <= '0;
         step_q     <= '0;
         ramp_cnt_q <= '0;
         err_q      <= '0;
         pdm_q      <= 1'b0;
         underrun_q <= 1'b0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         step_q     <= step_d;
         ramp_cnt_q <= ramp_cnt_d;
         err_q      <= err_d;
         pdm_q      <= pdm_d;
         underrun_q <= underrun_d;
         wd_q       <= wd_d;
      end
   end

endmodule
